// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit_deserializer block.
package bit_deser_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Bit counter must be able to hold DATA_W itself.
  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Valid/ready word output channel of the bit_deserializer.
interface bit_deserializer_if
  import bit_deser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/bit_deser_outbuf.sv
// One-entry holding register for received words, with sticky overflow.
module bit_deser_outbuf
  import bit_deser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_clr_ovf,
  bit_deserializer_if.master  out_if,
  output logic                o_overflow,
  output logic                o_load_ok_c
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovf;
  logic              w_accept;
  logic              w_drop;

  // A load fits when the slot is empty or is being drained this cycle.
  assign w_accept    = r_valid & out_if.out_ready;
  assign o_load_ok_c = i_load & (~r_valid | out_if.out_ready);
  assign w_drop      = i_load & ~o_load_ok_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (o_load_ok_c) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_if.out_data  = r_data;
  assign out_if.out_valid = r_valid;
  assign o_overflow       = r_ovf;

endmodule

// File: rtl/bit_deserializer.sv
// UART-style frame deserializer (start 0, DATA_W bits LSB-first, stop 1).
// Optional even-parity bit before the stop bit: define BIT_DESER_PARITY_EN.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_en,
  input  logic               serial_in,
  bit_deserializer_if.master out_if,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overflow,
  input  logic               clr_ovf,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int unsigned BCNT_W = bit_cnt_w(DATA_W);

  state_t              r_state, w_state_nxt;
  logic [BCNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                w_load_c;
  logic                w_load_ok_c;
`ifdef BIT_DESER_PARITY_EN
  logic                r_parity_err, w_parity_err_nxt;
  logic                r_par_bad, w_par_bad_nxt;
`endif

  // Frame sequencing; everything holds on cycles without bit_en.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_frame_err_nxt = 1'b0;
    w_load_c        = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    w_parity_err_nxt = 1'b0;
    w_par_bad_nxt    = r_par_bad;
`endif
    if (bit_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!serial_in) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
`ifdef BIT_DESER_PARITY_EN
            w_par_bad_nxt = 1'b0;
`endif
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {serial_in, r_shift[DATA_W-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
          if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
`ifdef BIT_DESER_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
`ifdef BIT_DESER_PARITY_EN
        ST_PARITY: begin
          w_parity_err_nxt = (^r_shift) ^ serial_in;
          w_par_bad_nxt    = (^r_shift) ^ serial_in;
          w_state_nxt      = ST_STOP;
        end
`endif
        ST_STOP: begin
          // A 0 here is a framing error, never a new start bit.
          if (serial_in) begin
`ifdef BIT_DESER_PARITY_EN
            w_load_c = ~r_par_bad;
`else
            w_load_c = 1'b1;
`endif
          end else begin
            w_frame_err_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
`ifdef BIT_DESER_PARITY_EN
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (w_load_ok_c) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
`ifdef BIT_DESER_PARITY_EN
      r_parity_err <= w_parity_err_nxt;
      r_par_bad    <= w_par_bad_nxt;
`endif
    end
  end

  bit_deser_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load_c),
    .i_data      (w_shift_nxt),
    .i_clr_ovf   (clr_ovf),
    .out_if      (out_if),
    .o_overflow  (overflow),
    .o_load_ok_c (w_load_ok_c)
  );

  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
`ifdef BIT_DESER_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_deserializer.sv
// Randomized and directed bench for bit_deserializer against a frame-level model.
module tb_bit_deserializer;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
`ifdef BIT_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_en;
  logic          serial_in;
  logic          frame_err;
  logic          parity_err;
  logic          overflow;
  logic          clr_ovf;
  logic [CW-1:0] frame_cnt;

  bit_deserializer_if #(.DATA_W(DW)) bif ();

  bit_deserializer #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .out_if     (bif),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus control
  bit rdy_rand, rdy_base, clr_rand, clr_base, force_rdy;

  // Expected state of the receiver as seen at its outputs
  bit          m_valid, m_ovf, m_ferr, m_perr;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare.
  task automatic step(input bit en, input bit sin, input bit ev_good,
                      input logic [DW-1:0] ev_data, input bit ev_ferr, input bit ev_perr);
    bit rdy, clr, set_ovf;
    bit_en    = en;
    serial_in = sin;
    rdy = force_rdy ? 1'b1 : (rdy_rand ? 1'($urandom_range(0, 1)) : rdy_base);
    clr = clr_rand ? ($urandom_range(0, 15) == 0) : clr_base;
    bif.out_ready = rdy;
    clr_ovf       = clr;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_ovf = 0; m_cnt = '0; m_ferr = 0; m_perr = 0;
    end else begin
      set_ovf = 0;
      if (ev_good) begin
        if (!m_valid || rdy) begin
          m_data  = ev_data;
          m_valid = 1;
          m_cnt   = m_cnt + 1'b1;
        end else begin
          set_ovf = 1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if (set_ovf) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_ferr = ev_ferr;
      m_perr = ev_perr;
    end
    #1;
    check_eq("out_valid",  32'(bif.out_valid), 32'(m_valid));
    check_eq("out_data",   32'(bif.out_data),  32'(m_data));
    check_eq("frame_err",  32'(frame_err),     32'(m_ferr));
    check_eq("parity_err", 32'(parity_err),    32'(m_perr));
    check_eq("overflow",   32'(overflow),      32'(m_ovf));
    check_eq("frame_cnt",  32'(frame_cnt),     32'(m_cnt));
  endtask

  task automatic idle(input int n, input bit rand_en);
    for (int i = 0; i < n; i++)
      step(rand_en ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b1, 0, '0, 0, 0);
    rst = 1'b0;
  endtask

  // Send one frame; bit_en fires on the last cycle of each period.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit pflip,
                            input int period, input bit stop_rdy);
    bit bits[$];
    int nb;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back((^d) ^ pflip);
    bits.push_back(stop);
    nb = bits.size();
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < period; c++) begin
        bit last, is_stop, is_par;
        last    = (c == period - 1);
        is_stop = (b == nb - 1);
        is_par  = PAR_EN && (b == nb - 2);
        force_rdy = last && is_stop && stop_rdy;
        step(last, bits[b], last && is_stop && stop && !(PAR_EN && pflip), d,
             last && is_stop && !stop, last && is_par && pflip);
        force_rdy = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; serial_in = 1'b1; clr_ovf = 1'b0; bif.out_ready = 1'b0;
    rdy_rand = 0; rdy_base = 1; clr_rand = 0; clr_base = 0; force_rdy = 0;
    m_valid = 0; m_data = '0; m_ovf = 0; m_cnt = '0; m_ferr = 0; m_perr = 0;

    step(1'b0, 1'b1, 0, '0, 0, 0);
    step(1'b0, 1'b1, 0, '0, 0, 0);
    rst = 1'b0;

    // 0xA5 back-to-back bits, consumer always ready
    idle(2, 0);
    send_frame(8'hA5, 1, 0, 1, 0);
    check_eq("a5_data", 32'(bif.out_data), 32'h0000_00A5);
    idle(3, 0);
    check_eq("a5_cnt", 32'(frame_cnt), 32'd1);

    // Slow bit_en, consumer stalled, second frame overflows
    do_reset();
    rdy_base = 0;
    send_frame(8'h3C, 1, 0, 4, 0);
    idle(4, 0);
    check_eq("3c_held", 32'(bif.out_data), 32'h0000_003C);
    send_frame(8'h81, 1, 0, 4, 0);
    idle(2, 0);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_data", 32'(bif.out_data), 32'h0000_003C);
    check_eq("ovf_cnt", 32'(frame_cnt), 32'd1);
    clr_base = 1; idle(1, 0); clr_base = 0;
    check_eq("ovf_clr", 32'(overflow), 32'd0);
    rdy_base = 1; idle(2, 0);

    // Bad stop bit, then a good frame right behind it
    do_reset();
    send_frame(8'h55, 0, 0, 1, 0);
    idle(2, 0);
    send_frame(8'h12, 1, 0, 2, 0);
    idle(3, 0);
    check_eq("ferr_cnt", 32'(frame_cnt), 32'd1);
    check_eq("ferr_next", 32'(bif.out_data), 32'h0000_0012);

    // Load coincides with acceptance of the held word
    do_reset();
    rdy_base = 0;
    send_frame(8'h11, 1, 0, 1, 0);
    idle(2, 0);
    send_frame(8'h22, 1, 0, 1, 1);
    check_eq("swap_valid", 32'(bif.out_valid), 32'd1);
    check_eq("swap_data", 32'(bif.out_data), 32'h0000_0022);
    check_eq("swap_ovf", 32'(overflow), 32'd0);
    rdy_base = 1; idle(2, 0);

    // Reset in the middle of a frame
    do_reset();
    step(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1'($urandom_range(0, 1)), 0, '0, 0, 0);
    do_reset();
    send_frame(8'h0F, 1, 0, 1, 0);
    idle(3, 0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'd1);
    check_eq("rst_data", 32'(bif.out_data), 32'h0000_000F);

    if (PAR_EN) begin
      do_reset();
      send_frame(8'h07, 1, 1, 1, 0);
      idle(2, 0);
      check_eq("par_bad_cnt", 32'(frame_cnt), 32'd0);
      send_frame(8'h07, 1, 0, 1, 0);
      check_eq("par_ok_data", 32'(bif.out_data), 32'h0000_0007);
      send_frame(8'h07, 0, 1, 2, 0);
      idle(2, 0);
      check_eq("par_both_cnt", 32'(frame_cnt), 32'd1);
    end

    // Random traffic
    do_reset();
    rdy_rand = 1; clr_rand = 1;
    for (int f = 0; f < 200; f++) begin
      send_frame(DW'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(1, 3), 0);
      idle($urandom_range(0, 3), 1);
    end
    rdy_rand = 0; rdy_base = 1; clr_rand = 0;
    idle(3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
